vga_timing_gen: RTL and testbench

//  Generates VGA raster timing: the DrawX/DrawY pixel coordinates and the active-high blank (display-enable) strobe that the

---
 rtl/vga_timing_gen_if.sv | 42 ++++
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the raster-timing signals between the timing generator and the
//   pixel-domain consumers (renderers, connector drivers).
//
//   pix_ce       pixel advance enable, driven by the consumer side
//   DrawX/DrawY  current raster column/row (10-bit)
//   blank        1 = current pixel is in the visible area
//   hs/vs        active-low horizontal/vertical sync
//   frame_start  one-cycle pulse when the raster lands on (0,0)
//
//   master: the timing generator.  slave: a consumer of the timing.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic       pix_ce;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;

  modport master (
    input  pix_ce,
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output frame_start
  );

  modport slave (
    output pix_ce,
    input  DrawX,
    input  DrawY,
    input  blank,
    input  hs,
    input  vs,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator. Horizontal and vertical counters advance one
//   pixel per pix_ce; a horizontal and a vertical phase FSM track which part
//   of the line/frame the raster is in, and the registered blank/hs/vs/
//   frame_start outputs are decoded from the next counter/phase values so they
//   are cycle-aligned with DrawX/DrawY.
//
// Ports
//   vga_clk   in   pixel-domain clock, all state on posedge
//   reset_n   in   asynchronous active-low reset
//   vga       master modport of vga_timing_gen_if (pix_ce in; DrawX, DrawY,
//             blank, hs, vs, frame_start out)
//
// Configuration
//   VGA_TIMING_PIPE_EN  when defined, blank/hs/vs pass through one extra
//                       register stage (advanced on pix_ce) to line up with a
//                       renderer whose RGB is registered one pixel later.
//                       DrawX/DrawY/frame_start are unaffected.
//
// Phase FSM states (same encoding for horizontal and vertical):
//   state     | meaning
//   ST_ACTIVE | visible pixels / visible lines
//   ST_FRONT  | front porch
//   ST_SYNC   | sync pulse (hs/vs low)
//   ST_BACK   | back porch, ends at counter wrap to 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [1:0] r_h_state;
  logic [1:0] r_v_state;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_frame_start;

  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic [1:0] w_h_state_next;
  logic [1:0] w_v_state_next;
  logic       w_blank_next;
  logic       w_hs_next;
  logic       w_vs_next;
  logic       w_frame_start_next;

  // Wrap on equality with the last position so the counters can never run
  // past the end of the line/frame.
  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);
  assign w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
  assign w_y_next = w_x_wrap ? (w_y_wrap ? 10'd0 : r_y + 10'd1) : r_y;

  always_comb begin
    w_h_state_next = r_h_state;
    case (r_h_state)
      ST_ACTIVE: if (w_x_next == H_FP_START)   w_h_state_next = ST_FRONT;
      ST_FRONT:  if (w_x_next == H_SYNC_START) w_h_state_next = ST_SYNC;
      ST_SYNC:   if (w_x_next == H_BP_START)   w_h_state_next = ST_BACK;
      ST_BACK:   if (w_x_next == 10'd0)        w_h_state_next = ST_ACTIVE;
      default:                                 w_h_state_next = ST_ACTIVE;
    endcase
  end

  // Vertical phase only moves at a line wrap, so vs switches at X=0.
  always_comb begin
    w_v_state_next = r_v_state;
    case (r_v_state)
      ST_ACTIVE: if (w_x_wrap && w_y_next == V_FP_START)   w_v_state_next = ST_FRONT;
      ST_FRONT:  if (w_x_wrap && w_y_next == V_SYNC_START) w_v_state_next = ST_SYNC;
      ST_SYNC:   if (w_x_wrap && w_y_next == V_BP_START)   w_v_state_next = ST_BACK;
      ST_BACK:   if (w_x_wrap && w_y_next == 10'd0)        w_v_state_next = ST_ACTIVE;
      default:                                             w_v_state_next = ST_ACTIVE;
    endcase
  end

  assign w_blank_next       = (w_h_state_next == ST_ACTIVE) && (w_v_state_next == ST_ACTIVE);
  assign w_hs_next          = (w_h_state_next != ST_SYNC);
  assign w_vs_next          = (w_v_state_next != ST_SYNC);
  assign w_frame_start_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);

  // Reset parks the raster on its last position (inside both back porches),
  // so the first pix_ce after release lands on (0,0) with a fresh frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_h_state     <= ST_BACK;
      r_v_state     <= ST_BACK;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (vga.pix_ce) begin
        r_x           <= w_x_next;
        r_y           <= w_y_next;
        r_h_state     <= w_h_state_next;
        r_v_state     <= w_v_state_next;
        r_blank       <= w_blank_next;
        r_hs          <= w_hs_next;
        r_vs          <= w_vs_next;
        r_frame_start <= w_frame_start_next;
      end
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic r_blank_d;
  logic r_hs_d;
  logic r_vs_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_d <= 1'b0;
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
    end else if (vga.pix_ce) begin
      r_blank_d <= r_blank;
      r_hs_d    <= r_hs;
      r_vs_d    <= r_vs;
    end
  end

  assign vga.blank = r_blank_d;
  assign vga.hs    = r_hs_d;
  assign vga.vs    = r_vs_d;
`else
  assign vga.blank = r_blank;
  assign vga.hs    = r_hs;
  assign vga.vs    = r_vs;
`endif

  assign vga.DrawX       = r_x;
  assign vga.DrawY       = r_y;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int x, y, hph, vph;
    bit blank, hs, vs, fs;
    int tag;
  } exp_t;

  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big_n;
  logic rst_small_n;

  vga_timing_gen_if if_big();
  vga_timing_gen_if if_small();

  vga_timing_gen dut_big (
    .vga_clk (clk),
    .reset_n (rst_big_n),
    .vga     (if_big)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .vga_clk (clk),
    .reset_n (rst_small_n),
    .vga     (if_small)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: linear pixel index within the frame
  function automatic int h_total(input cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int f_total(input cfg_t c);
    return h_total(c) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  function automatic exp_t decode(input cfg_t c, input int p);
    exp_t e;
    e.x = p % h_total(c);
    e.y = p / h_total(c);
    e.hph = (e.x < c.ha) ? 0 : (e.x < c.ha + c.hf) ? 1 : (e.x < c.ha + c.hf + c.hs) ? 2 : 3;
    e.vph = (e.y < c.va) ? 0 : (e.y < c.va + c.vf) ? 1 : (e.y < c.va + c.vf + c.vs) ? 2 : 3;
    e.blank = (e.x < c.ha) && (e.y < c.va);
    e.hs = !((e.x >= c.ha + c.hf) && (e.x < c.ha + c.hf + c.hs));
    e.vs = !((e.y >= c.va + c.vf) && (e.y < c.va + c.vf + c.vs));
    e.fs = 1'b0;
    e.tag = 0;
    return e;
  endfunction

  task automatic model_step(input cfg_t c, inout int p, inout bit dbl, inout bit dhs, inout bit dvs,
                            input bit rst_n, input bit ce, input int tag, output exp_t e);
    exp_t cur;
    if (!rst_n) begin
      p = f_total(c) - 1;
      dbl = 1'b0; dhs = 1'b1; dvs = 1'b1;
      e = decode(c, p);
    end else if (ce) begin
      cur = decode(c, p);
      dbl = cur.blank; dhs = cur.hs; dvs = cur.vs;
      p = (p + 1) % f_total(c);
      e = decode(c, p);
      e.fs = (p == 0);
    end else begin
      e = decode(c, p);
    end
`ifdef VGA_TIMING_PIPE_EN
    e.blank = dbl; e.hs = dhs; e.vs = dvs;
`endif
    e.tag = tag;
  endtask

  cfg_t cfg_big, cfg_small;
  int p_big, p_small;
  bit dbl_b, dhs_b, dvs_b, dbl_s, dhs_s, dvs_s;
  exp_t q_big[$];
  exp_t q_small[$];

  task automatic step_big(input bit rst_n, input bit ce, input int tag);
    exp_t e;
    @(negedge clk);
    rst_big_n = rst_n;
    if_big.pix_ce = ce;
    model_step(cfg_big, p_big, dbl_b, dhs_b, dvs_b, rst_n, ce, tag, e);
    q_big.push_back(e);
  endtask

  task automatic step_small(input bit rst_n, input bit ce, input int tag);
    exp_t e;
    @(negedge clk);
    rst_small_n = rst_n;
    if_small.pix_ce = ce;
    model_step(cfg_small, p_small, dbl_s, dhs_s, dvs_s, rst_n, ce, tag, e);
    q_small.push_back(e);
  endtask

  // ---------------- monitors
  int big_hs_low = 0, big_blank_hi = 0;
  int sm_vs_low = 0, sm_blank_hi = 0;
  int sm_cyc = 0, sm_last_fs = -1;
  int sm_periods[$];

  always @(posedge clk) begin : mon_big
    exp_t e;
    #1;
    if (q_big.size() > 0) begin
      e = q_big.pop_front();
      chk("big_x", int'(if_big.DrawX), e.x);
      chk("big_y", int'(if_big.DrawY), e.y);
      chk("big_blank", int'(if_big.blank), int'(e.blank));
      chk("big_hs", int'(if_big.hs), int'(e.hs));
      chk("big_vs", int'(if_big.vs), int'(e.vs));
      chk("big_frame_start", int'(if_big.frame_start), int'(e.fs));
      chk("big_h_phase", int'(dut_big.r_h_state), e.hph);
      chk("big_v_phase", int'(dut_big.r_v_state), e.vph);
      if (e.tag == 1) begin
        if (!if_big.hs) big_hs_low++;
        if (if_big.blank) big_blank_hi++;
      end
    end
  end

  always @(posedge clk) begin : mon_small
    exp_t e;
    #1;
    sm_cyc++;
    if (q_small.size() > 0) begin
      e = q_small.pop_front();
      chk("sm_x", int'(if_small.DrawX), e.x);
      chk("sm_y", int'(if_small.DrawY), e.y);
      chk("sm_blank", int'(if_small.blank), int'(e.blank));
      chk("sm_hs", int'(if_small.hs), int'(e.hs));
      chk("sm_vs", int'(if_small.vs), int'(e.vs));
      chk("sm_frame_start", int'(if_small.frame_start), int'(e.fs));
      chk("sm_h_phase", int'(dut_small.r_h_state), e.hph);
      chk("sm_v_phase", int'(dut_small.r_v_state), e.vph);
      if (e.tag == 1) begin
        if (!if_small.vs) sm_vs_low++;
        if (if_small.blank) sm_blank_hi++;
      end
      if (e.tag == 2 && if_small.frame_start) begin
        if (sm_last_fs >= 0) sm_periods.push_back(sm_cyc - sm_last_fs);
        sm_last_fs = sm_cyc;
      end
    end
  end

  // ---------------- stimulus
  task automatic big_seq();
    for (int i = 0; i < 3; i++) step_big(1'b0, 1'b1, 0);
    for (int i = 0; i < 800; i++) step_big(1'b1, 1'b1, 1);
    @(posedge clk); #2;
    chk("big_line_hs_low_cycles", big_hs_low, 96);
    chk("big_line_blank_cycles", big_blank_hi, 640);
    // advance to (300,1) and reset asynchronously mid-line
    for (int i = 0; i < 301; i++) step_big(1'b1, 1'b1, 0);
    step_big(1'b0, 1'b0, 0);
    #1;
    chk("big_async_rst_x", int'(if_big.DrawX), h_total(cfg_big) - 1);
    chk("big_async_rst_y", int'(if_big.DrawY), cfg_big.va + cfg_big.vf + cfg_big.vs + cfg_big.vb - 1);
    chk("big_async_rst_blank", int'(if_big.blank), 0);
    chk("big_async_rst_hs", int'(if_big.hs), 1);
    step_big(1'b0, 1'b1, 0);
    for (int i = 0; i < 2000; i++) step_big(1'b1, 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic small_seq();
    int guard;
    for (int i = 0; i < 3; i++) step_small(1'b0, 1'b1, 0);
    for (int i = 0; i < 3 * 312; i++) step_small(1'b1, 1'b1, 1);
    @(posedge clk); #2;
    chk("sm_vs_low_cycles", sm_vs_low, 3 * S_VS * (S_HA + S_HF + S_HS + S_HB));
    chk("sm_blank_cycles", sm_blank_hi, 3 * S_HA * S_VA);
    // frame period with continuous pix_ce
    sm_periods.delete(); sm_last_fs = -1;
    for (int i = 0; i < 3 * 312; i++) step_small(1'b1, 1'b1, 2);
    @(posedge clk); #2;
    chk("sm_period_count_ce1", sm_periods.size(), 2);
    foreach (sm_periods[k]) chk("sm_period_ce1", sm_periods[k], 312);
    // frame period with pix_ce 1-in-4
    sm_periods.delete(); sm_last_fs = -1;
    for (int i = 0; i < 3 * 1248; i++) step_small(1'b1, 1'(i % 4 == 0), 2);
    @(posedge clk); #2;
    chk("sm_period_seen_ce4", int'(sm_periods.size() >= 1), 1);
    foreach (sm_periods[k]) chk("sm_period_ce4", sm_periods[k], 1248);
    // reach (10,5) then async reset
    guard = 0;
    while (p_small != 5 * 24 + 10 && guard < 400) begin
      step_small(1'b1, 1'b1, 0);
      guard++;
    end
    chk("sm_reach_mid_frame", p_small, 5 * 24 + 10);
    step_small(1'b0, 1'b0, 0);
    #1;
    chk("sm_async_rst_x", int'(if_small.DrawX), 23);
    chk("sm_async_rst_y", int'(if_small.DrawY), 12);
    chk("sm_async_rst_vs", int'(if_small.vs), 1);
    chk("sm_async_rst_fs", int'(if_small.frame_start), 0);
    // random pix_ce with rare resets
    for (int i = 0; i < 3000; i++)
      step_small(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) == 0), 0);
  endtask

  initial begin
    cfg_big   = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33};
    cfg_small = '{ha:S_HA, hf:S_HF, hs:S_HS, hb:S_HB, va:S_VA, vf:S_VF, vs:S_VS, vb:S_VB};
    p_big = f_total(cfg_big) - 1;
    p_small = f_total(cfg_small) - 1;
    dbl_b = 1'b0; dhs_b = 1'b1; dvs_b = 1'b1;
    dbl_s = 1'b0; dhs_s = 1'b1; dvs_s = 1'b1;
    rst_big_n = 1'b0;
    rst_small_n = 1'b0;
    if_big.pix_ce = 1'b1;
    if_small.pix_ce = 1'b1;
    fork
      big_seq();
      small_seq();
    join
    @(posedge clk); #2;
    chk("big_queue_drained", q_big.size(), 0);
    chk("sm_queue_drained", q_small.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
